cone_vector_driver: RTL and testbench

- Sequential driver and reader for the flattened combinational cones in this library, such as the single-output partial cones of the ISCAS89 benchmarks.
- Deserialises test vectors from a bit-serial stream and applies each vector in parallel to the cone's primary inputs.
- After a settle window it samples the cone's single output and compacts the responses into a MISR signature.
- Fills the role of the state elements that the combinational conversion stripped out, and sits between the bench or BIST controller and the cone.

---
 rtl/cone_vector_driver.sv | 146 ++++++++++++++
 tb/tb_cone_vector_driver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cone_vector_driver.sv
// Bit-serial vector loader and MISR response compactor for a single-output combinational cone.
// Each vector is shifted in, applied in parallel, allowed to settle, and its response folded into the signature.
module cone_vector_driver #(
    parameter int              NIN        = 25,
    parameter int              SIG_W      = 16,
    parameter logic [SIG_W-1:0] POLY      = 16'h1021,
    parameter logic [SIG_W-1:0] SEED      = 16'hFFFF,
    parameter int              SETTLE_CYC = 2
) (
    input  logic             CK,
    input  logic             RESETN,
    input  logic             start,
    input  logic [15:0]      num_vec,
    input  logic             si_valid,
    input  logic             si_data,
    output logic             si_ready,
    output logic [NIN-1:0]   vec_out,
    input  logic             resp_in,
    output logic             cap_valid,
    output logic             cap_data,
    output logic [SIG_W-1:0] signature,
    output logic [15:0]      vec_count,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (NIN > 1) ? $clog2(NIN) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(NIN - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]       state_q,     state_d;
    logic [NIN-1:0]   shreg_q,     shreg_d;
    logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [3:0]       settle_q,    settle_d;
    logic [NIN-1:0]   vec_out_q,   vec_out_d;
    logic [15:0]      num_vec_q,   num_vec_d;
    logic [15:0]      vec_count_q, vec_count_d;
    logic [SIG_W-1:0] sig_q,       sig_d;
    logic             cap_valid_q, cap_valid_d;
    logic             cap_data_q,  cap_data_d;

    // One Galois-style MISR step with the response bit injected at bit 0.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s, input logic b);
        logic [SIG_W-1:0] n;
        n = {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0);
        return n ^ {{(SIG_W-1){1'b0}}, b};
    endfunction

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        settle_d    = settle_q;
        vec_out_d   = vec_out_q;
        num_vec_d   = num_vec_q;
        vec_count_d = vec_count_q;
        sig_d       = sig_q;
        cap_valid_d = 1'b0;
        cap_data_d  = cap_data_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    num_vec_d   = num_vec;
                    vec_count_d = 16'd0;
                    sig_d       = SEED;
                    bit_cnt_d   = '0;
                    state_d     = (num_vec == 16'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (si_valid) begin
                    shreg_d = {shreg_q[NIN-2:0], si_data};
                    // The completing bit goes straight to the cone so it never sees a partial vector.
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        vec_out_d = shreg_d;
                        settle_d  = 4'd0;
                        state_d   = S_SETTLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_CAPTURE: begin
                sig_d       = misr_step(sig_q, resp_in);
                cap_data_d  = resp_in;
                cap_valid_d = 1'b1;
                vec_count_d = vec_count_q + 16'd1;
                state_d     = (vec_count_d == num_vec_q) ? S_DONE : S_LOAD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (!RESETN) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            settle_q    <= 4'd0;
            vec_out_q   <= '0;
            num_vec_q   <= 16'd0;
            vec_count_q <= 16'd0;
            sig_q       <= SEED;
            cap_valid_q <= 1'b0;
            cap_data_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            settle_q    <= settle_d;
            vec_out_q   <= vec_out_d;
            num_vec_q   <= num_vec_d;
            vec_count_q <= vec_count_d;
            sig_q       <= sig_d;
            cap_valid_q <= cap_valid_d;
            cap_data_q  <= cap_data_d;
        end
    end

    assign si_ready  = (state_q == S_LOAD);
    assign busy      = (state_q == S_LOAD) || (state_q == S_SETTLE) || (state_q == S_CAPTURE);
    assign done      = (state_q == S_DONE);
    assign vec_out   = vec_out_q;
    assign cap_valid = cap_valid_q;
    assign cap_data  = cap_data_q;
    assign signature = sig_q;
    assign vec_count = vec_count_q;

endmodule

// File: tb/tb_cone_vector_driver.sv
// Bench for cone_vector_driver: table-driven single-vector runs, a capture scoreboard and multi-cycle corner sequences.
module tb_cone_vector_driver;

    localparam int          NIN    = 25;
    localparam int          SETTLE = 2;
    localparam logic [15:0] POLY   = 16'h1021;
    localparam logic [15:0] SEED   = 16'hFFFF;

    logic           CK = 1'b0;
    logic           RESETN = 1'b0;
    logic           start = 1'b0;
    logic [15:0]    num_vec = 16'd0;
    logic           si_valid = 1'b0;
    logic           si_data = 1'b0;
    logic           si_ready;
    logic [NIN-1:0] vec_out;
    logic           resp_in = 1'b0;
    logic           cap_valid;
    logic           cap_data;
    logic [15:0]    signature;
    logic [15:0]    vec_count;
    logic           busy;
    logic           done;

    cone_vector_driver #(
        .NIN(NIN), .SIG_W(16), .POLY(POLY), .SEED(SEED), .SETTLE_CYC(SETTLE)
    ) dut (
        .CK(CK), .RESETN(RESETN), .start(start), .num_vec(num_vec),
        .si_valid(si_valid), .si_data(si_data), .si_ready(si_ready),
        .vec_out(vec_out), .resp_in(resp_in), .cap_valid(cap_valid),
        .cap_data(cap_data), .signature(signature), .vec_count(vec_count),
        .busy(busy), .done(done)
    );

    always #5 CK = ~CK;

    int n_tests = 0;
    int n_fail  = 0;
    int cap_pulses = 0;

    typedef struct {
        logic        cap;
        logic [15:0] sig;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];

    logic [15:0] model_sig = SEED;
    logic [15:0] model_cnt = 16'd0;

    // stream bit i is the i-th bit sent on the serial port
    typedef struct {
        logic [NIN-1:0] stream;
        logic           resp;
        logic [NIN-1:0] exp_vout;
        logic [15:0]    exp_sig;
    } vec_t;
    vec_t tbl[6];

    function automatic logic [15:0] misr(input logic [15:0] s, input logic b);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ POLY;
        n[0] = n[0] ^ b;
        return n;
    endfunction

    function automatic logic [NIN-1:0] rev(input logic [NIN-1:0] v);
        logic [NIN-1:0] r;
        for (int i = 0; i < NIN; i++) r[NIN-1-i] = v[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every capture pulse must match the oldest pushed expectation.
    always @(posedge CK) begin
        #1;
        if (cap_valid === 1'b1) begin
            exp_t e;
            cap_pulses++;
            if (sb.size() == 0) begin
                check("unexpected_capture", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_cap_data", {31'd0, cap_data}, {31'd0, e.cap});
                check("sb_signature", {16'd0, signature}, {16'd0, e.sig});
                check("sb_vec_count", {16'd0, vec_count}, {16'd0, e.cnt});
            end
        end
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        num_vec = n;
        model_sig = SEED;
        model_cnt = 16'd0;
        tick();
        start = 1'b0;
    endtask

    task automatic send_vec(input logic [NIN-1:0] v, input int first, input int count,
                            input bit stall, input bit hold, input logic resp, input bit push);
        resp_in = resp;
        if (push) begin
            model_sig = misr(model_sig, resp);
            model_cnt = model_cnt + 16'd1;
            sb.push_back('{resp, model_sig, model_cnt});
        end
        for (int i = first; i < first + count; i++) begin
            if (stall) begin
                while ($urandom_range(0, 1) == 1) begin
                    si_valid = 1'b0;
                    si_data  = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            si_valid = 1'b1;
            si_data  = v[i];
            tick();
        end
        si_valid = hold;
        si_data  = 1'b1;
    endtask

    task automatic wait_capture();
        repeat (SETTLE + 1) tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_si_ready"},  {31'd0, si_ready},  32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
        check({tag, "_done"},      {31'd0, done},      32'd0);
        check({tag, "_vec_out"},   {7'd0, vec_out},    32'd0);
        check({tag, "_vec_count"}, {16'd0, vec_count}, 32'd0);
        check({tag, "_signature"}, {16'd0, signature}, 32'h0000FFFF);
        check({tag, "_cap_valid"}, {31'd0, cap_valid}, 32'd0);
    endtask

    logic [NIN-1:0] va, vb, vc;
    int pulses0;

    initial begin
        tbl[0] = '{25'h0000000, 1'b1, 25'h0000000, 16'hEFDE};
        tbl[1] = '{25'h0000000, 1'b0, 25'h0000000, 16'hEFDF};
        tbl[2] = '{25'h0000001, 1'b1, 25'h1000000, 16'hEFDE};
        tbl[3] = '{25'h1000000, 1'b0, 25'h0000001, 16'hEFDF};
        tbl[4] = '{25'h0000003, 1'b1, 25'h1800000, 16'hEFDE};
        tbl[5] = '{25'h1555555, 1'b0, 25'h1555555, 16'hEFDF};

        // reset held for two cycles
        RESETN = 1'b0;
        repeat (2) @(posedge CK);
        #1;
        RESETN = 1'b1;
        check_reset_state("reset");
        tick();

        // single-vector runs from the table
        for (int k = 0; k < 6; k++) begin
            do_start(16'd1);
            check("tbl_busy", {31'd0, busy}, 32'd1);
            send_vec(tbl[k].stream, 0, NIN, 1'b0, 1'b0, tbl[k].resp, 1'b1);
            check("tbl_vec_out", {7'd0, vec_out}, {7'd0, tbl[k].exp_vout});
            wait_capture();
            check("tbl_signature", {16'd0, signature}, {16'd0, tbl[k].exp_sig});
            check("tbl_vec_count", {16'd0, vec_count}, 32'd1);
            check("tbl_done", {31'd0, done}, 32'd1);
            check("tbl_cap_data", {31'd0, cap_data}, {31'd0, tbl[k].resp});
        end

        // random stalls plus a start pulse in the middle of LOAD
        va = 25'h0F0F0F0;
        do_start(16'd1);
        send_vec(va, 0, 12, 1'b1, 1'b0, 1'b1, 1'b1);
        start = 1'b1;
        num_vec = 16'd5;
        tick();
        start = 1'b0;
        num_vec = 16'd1;
        check("stall_vec_out_held", {7'd0, vec_out}, {7'd0, tbl[5].exp_vout});
        check("stall_busy", {31'd0, busy}, 32'd1);
        send_vec(va, 12, NIN - 12, 1'b1, 1'b0, 1'b1, 1'b0);
        check("stall_vec_out", {7'd0, vec_out}, {7'd0, rev(va)});
        wait_capture();
        check("stall_done", {31'd0, done}, 32'd1);
        check("stall_vec_count", {16'd0, vec_count}, 32'd1);

        // si_valid held high through SETTLE/CAPTURE must not consume bits
        do_start(16'd2);
        send_vec(25'h1FFFFFF, 0, NIN, 1'b0, 1'b1, 1'b0, 1'b1);
        check("settle_ready_low", {31'd0, si_ready}, 32'd0);
        wait_capture();
        send_vec(25'h0000000, 0, NIN, 1'b0, 1'b0, 1'b1, 1'b1);
        check("settle_vec2_out", {7'd0, vec_out}, 32'd0);
        wait_capture();
        check("settle_done", {31'd0, done}, 32'd1);
        check("settle_vec_count", {16'd0, vec_count}, 32'd2);

        // num_vec=0 goes straight to DONE with a fresh seed
        do_start(16'd0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        check("zero_signature", {16'd0, signature}, 32'h0000FFFF);
        check("zero_vec_count", {16'd0, vec_count}, 32'd0);

        // three-vector run
        va = 25'h1234567; vb = 25'h0ABCDEF; vc = 25'h1FFFFFF;
        pulses0 = cap_pulses;
        do_start(16'd3);
        send_vec(va, 0, NIN, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_capture();
        check("multi_busy_mid", {31'd0, busy}, 32'd1);
        send_vec(vb, 0, NIN, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_capture();
        send_vec(vc, 0, NIN, 1'b0, 1'b0, 1'b1, 1'b1);
        check("multi_vec_out", {7'd0, vec_out}, {7'd0, rev(vc)});
        wait_capture();
        tick();
        check("multi_pulses", cap_pulses - pulses0, 32'd3);
        check("multi_done", {31'd0, done}, 32'd1);
        check("multi_signature", {16'd0, signature}, 32'h00008F1A);

        // restart from DONE reseeds the MISR
        do_start(16'd1);
        check("restart_signature", {16'd0, signature}, 32'h0000FFFF);
        check("restart_busy", {31'd0, busy}, 32'd1);
        send_vec(va, 0, NIN, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_capture();
        check("restart_sig_end", {16'd0, signature}, 32'h0000EFDF);

        // reset after 10 bits of vector 2, then repeat the run cleanly
        do_start(16'd3);
        send_vec(va, 0, NIN, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_capture();
        send_vec(vb, 0, 10, 1'b0, 1'b0, 1'b0, 1'b0);
        RESETN = 1'b0;
        tick();
        tick();
        RESETN = 1'b1;
        sb.delete();
        check_reset_state("midreset");
        tick();
        do_start(16'd3);
        send_vec(va, 0, NIN, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_capture();
        send_vec(vb, 0, NIN, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rerun_vec_out", {7'd0, vec_out}, {7'd0, rev(vb)});
        wait_capture();
        send_vec(vc, 0, NIN, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_capture();
        check("rerun_signature", {16'd0, signature}, 32'h00008F1A);
        check("rerun_done", {31'd0, done}, 32'd1);
        check("rerun_vec_count", {16'd0, vec_count}, 32'd3);

        repeat (3) tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
